alu_share_arbiter: RTL

Round-robin arbiter and sequencer that shares the single 8-bit ALU, including its 16-way result select mux, among four requesters. Each requester presents a 4-bit opcode and two 8-bit operands. The block grants one requester at a time and drives the ALU operands and mux select from registers. After a fixed latency it captures the mux output and returns it with a one-cycle acknowledge. It sits between the instruction/control units and the ALU datapath.

---
 rtl/alu_share_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one 8-bit ALU among four requesters.
// A grant loads registered ALU operands/select; the mux output is captured after RESULT_LAT cycles.
module alu_share_arbiter #(
  parameter int RESULT_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  ack,
  output logic [7:0]  result,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_y
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(RESULT_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  ack_q, ack_d;
  logic [7:0]  result_q, result_d;
  logic [1:0]  grant_id_q, grant_id_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [3:0]  alu_sel_q, alu_sel_d;

  // Rotate the request vector so bit 0 is the requester at the priority pointer.
  logic [7:0]  req_rot;
  logic [1:0]  pick_off;
  logic [1:0]  pick;

  always_comb begin
    req_rot = {req, req} >> ptr_q;
    if (req_rot[0])      pick_off = 2'd0;
    else if (req_rot[1]) pick_off = 2'd1;
    else if (req_rot[2]) pick_off = 2'd2;
    else                 pick_off = 2'd3;
    pick = ptr_q + pick_off;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    result_d   = result_q;
    grant_id_d = grant_id_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_id_d = pick;
          alu_sel_d  = req_op[{pick, 2'b00} +: 4];
          alu_a_d    = req_a[{pick, 3'b000} +: 8];
          alu_b_d    = req_b[{pick, 3'b000} +: 8];
          cnt_d      = CNT_INIT;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          result_d = alu_y;
          ack_d    = 4'b0001 << grant_id_q;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        ptr_d   = grant_id_q + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      result_q   <= '0;
      grant_id_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      result_q   <= result_d;
      grant_id_q <= grant_id_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
    end
  end

  assign ack      = ack_q;
  assign result   = result_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_sel  = alu_sel_q;

endmodule
